// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-write and status bundle between the bus-side logic and the UART transmitter.
interface uart_tx_if;

  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       tx_busy;
  logic       tx;

  modport master (
    output wr_en,
    output wr_data,
    input  full,
    input  empty,
    input  overflow,
    input  tx_busy,
    input  tx
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output full,
    output empty,
    output overflow,
    output tx_busy,
    output tx
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word fall-through FIFO with registered full/empty flags.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              push_ok_s;
  logic              pop_ok_s;

  // Pointer, count and flag next-state; a push into a full FIFO is refused.
  always_comb begin
    push_ok_s = push && !full_q;
    pop_ok_s  = pop && !empty_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    if (push_ok_s) begin
      wptr_d = wptr_q + PTR_W'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_ok_s) begin
      rptr_d = rptr_q + PTR_W'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    full_d  = (cnt_d == CNT_FULL);
    empty_d = (cnt_d == CNT_W'(0));
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= PTR_W'(0);
      rptr_q  <= PTR_W'(0);
      cnt_q   <= CNT_W'(0);
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage array; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wptr_q] <= din;
    end
  end

  assign dout  = mem_q[rptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: TX FIFO feeding a start/data/stop serializer with a glitch-free tx flop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  uart_tx_if.slave  bus
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int BAUD_W     = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W      = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q, ovf_d;

  logic                 pop_s;
  logic                 baud_end_s;
  logic [DATA_BITS-1:0] fifo_dout_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;

  uart_tx_fifo #(
    .DATA_W (DATA_BITS),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.wr_en),
    .din   (bus.wr_data),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Frame sequencer; tx and busy are derived from the next state so both stay registered.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    pop_s      = 1'b0;
    baud_end_s = (baud_q == BAUD_LAST);
    ovf_d      = bus.wr_en && fifo_full_s;

    case (state_q)
      IDLE: begin
        baud_d = BAUD_W'(0);
        if (!fifo_empty_s) begin
          shift_d = fifo_dout_s;
          pop_s   = 1'b1;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (baud_end_s) begin
          baud_d  = BAUD_W'(0);
          idx_d   = IDX_W'(0);
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_end_s) begin
          baud_d  = BAUD_W'(0);
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            idx_d   = IDX_W'(0);
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_end_s) begin
          baud_d = BAUD_W'(0);
          // Chain straight into the next start bit when another byte is waiting.
          if (!fifo_empty_s) begin
            shift_d = fifo_dout_s;
            pop_s   = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        baud_d  = BAUD_W'(0);
        idx_d   = IDX_W'(0);
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Sequencer state, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= BAUD_W'(0);
      idx_q   <= IDX_W'(0);
      shift_q <= DATA_BITS'(0);
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.full     = fifo_full_s;
  assign bus.empty    = fifo_empty_s;
  assign bus.overflow = ovf_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx       = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clocks per bit, plus a default-rate start-bit timing probe.
module tb_uart_tx;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  uart_tx_if bus ();
  uart_tx_if bus2 ();

  uart_tx #(
    .CLK_FREQ   (1_000_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  uart_tx dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  logic tx_log   [0:1023];
  logic busy_log [0:1023];
  int   cnt;
  int   bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    step();
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      tx_log[i]   = bus.tx;
      busy_log[i] = bus.tx_busy;
      step();
    end
  endtask

  task automatic check_frame(input string tag, input int s, input logic [7:0] exp);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b[i] = tx_log[s + 15 + 10 * i];
    end
    check({tag, "_start"}, {31'd0, tx_log[s + 5]}, 32'd0);
    check({tag, "_data"}, {24'd0, b}, {24'd0, exp});
    check({tag, "_stop"}, {31'd0, tx_log[s + 95]}, 32'd1);
  endtask

  function automatic int count_busy(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) begin
      if (busy_log[i] === 1'b1) c++;
    end
    return c;
  endfunction

  function automatic int count_low(input int from, input int to);
    int c = 0;
    for (int i = from; i < to; i++) begin
      if (tx_log[i] !== 1'b1) c++;
    end
    return c;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wr_data  = 8'h00;
    bus2.wr_en   = 1'b0;
    bus2.wr_data = 8'h00;
    repeat (3) step();

    check("rst_tx", {31'd0, bus.tx}, 32'd1);
    check("rst_busy", {31'd0, bus.tx_busy}, 32'd0);
    check("rst_empty", {31'd0, bus.empty}, 32'd1);
    check("rst_full", {31'd0, bus.full}, 32'd0);
    check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    reset = 1'b0;

    // Idle line stability
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.overflow !== 1'b0) bad++;
      step();
    end
    check("idle_stable", bad, 32'd0);

    // Single byte 0x41
    wr(8'h41);
    check("single_empty_fall", {31'd0, bus.empty}, 32'd0);
    capture(120);
    check("single_pre_tx", {31'd0, tx_log[0]}, 32'd1);
    check("single_latency", {31'd0, tx_log[1]}, 32'd0);
    check("single_busy_rise", {31'd0, busy_log[1]}, 32'd1);
    check_frame("single", 1, 8'h41);
    check("single_busy_len", count_busy(120), 32'd100);
    check("single_empty_end", {31'd0, bus.empty}, 32'd1);

    // Back-to-back 0x55, 0xA3
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h55;
    step();
    bus.wr_data = 8'hA3;
    step();
    bus.wr_en   = 1'b0;
    capture(220);
    check_frame("b2b_f1", 0, 8'h55);
    check("b2b_stop_end", {31'd0, tx_log[99]}, 32'd1);
    check("b2b_no_gap", {31'd0, tx_log[100]}, 32'd0);
    check_frame("b2b_f2", 100, 8'hA3);
    check("b2b_busy_len", count_busy(220), 32'd200);

    // Fill to full, then overflow on a sixth write
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          bus.wr_en   = 1'b1;
          bus.wr_data = 8'(i + 1);
          step();
          if (i == 4) check("fill_full", {31'd0, bus.full}, 32'd1);
          if (i == 5) check("fill_ovf_pulse", {31'd0, bus.overflow}, 32'd1);
        end
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        step();
        check("fill_ovf_clear", {31'd0, bus.overflow}, 32'd0);
      end
      begin
        capture(600);
      end
    join
    for (int f = 0; f < 5; f++) begin
      check_frame("fill", 2 + 100 * f, 8'(f + 1));
    end
    check("fill_no_extra", count_low(502, 600), 32'd0);
    check("fill_empty_end", {31'd0, bus.empty}, 32'd1);

    // Reset in the middle of a 0xFF frame with a byte still queued
    wr(8'hFF);
    wr(8'h00);
    repeat (34) step();
    reset = 1'b1;
    #1;
    check("midrst_tx", {31'd0, bus.tx}, 32'd1);
    check("midrst_empty", {31'd0, bus.empty}, 32'd1);
    check("midrst_busy", {31'd0, bus.tx_busy}, 32'd0);
    step();
    reset = 1'b0;
    step();
    wr(8'h0F);
    capture(150);
    check_frame("post_rst", 1, 8'h0F);
    check("post_rst_no_stale", count_low(101, 150), 32'd0);

    // Default rate: start bit must last 10416 clocks
    bus2.wr_en   = 1'b1;
    bus2.wr_data = 8'h01;
    step();
    bus2.wr_en   = 1'b0;
    step();
    check("dflt_latency", {31'd0, bus2.tx}, 32'd0);
    cnt = 0;
    while (bus2.tx === 1'b0 && cnt < 20000) begin
      cnt++;
      step();
    end
    check("dflt_start_len", cnt, 32'd10416);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter for the MCU serial port: 8 data bits, no parity, 1 stop bit, LSB first, line idles high.
- Bytes from the bus-side peripheral logic are written into a small TX FIFO and serialized on tx at the configured baud.
- It is the transmit counterpart to the serial stimulus driven into rx, so the MCU can echo or report back over tx.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- BIT_CYCLES = CLK_FREQ/BAUD (integer division), derived localparam. The default value is 10416 clocks per bit.
- FIFO_DEPTH, 4, TX FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- wr_en  in  1  write strobe, one byte per cycle.
- wr_data  in  8  byte to transmit.
- full  out  1  FIFO full; a write is accepted only when full is 0.
- empty  out  1  FIFO empty.
- overflow  out  1  one-cycle pulse when wr_en is high while full is 1; that byte is dropped.
- tx_busy  out  1  high whenever the FSM is not in IDLE.
- tx  out  1  serial line out, driven from a flop (no glitches).

Behaviour:
- Reset (async, immediate):
  - tx=1, tx_busy=0, empty=1, full=0, overflow=0.
  - FIFO pointers, count, shift register and bit counter all go to 0; FSM goes to IDLE.
  - Reset mid-frame aborts the frame: tx goes high at once and pending bytes are discarded.
- FIFO:
  - Synchronous FIFO; full and empty are registered.
  - Write accepted iff wr_en && !full. Pop happens when the FSM loads a byte.
  - Simultaneous write and pop: when not full, both occur and the count is unchanged. When full, the write is dropped with an overflow pulse, even if a pop happens in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP. A baud counter counts 0..BIT_CYCLES-1 and a bit index counts 0..7.
  - IDLE: tx=1. If !empty: load the FIFO head into the shift register, pop it, clear the baud counter, go to START.
  - START: tx=0 for exactly BIT_CYCLES clocks, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for BIT_CYCLES clocks. Then shift right and increment the index. After bit 7 completes, go to STOP.
  - STOP: tx=1 for BIT_CYCLES clocks. At the end, if !empty, load and pop the next byte and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- Latency:
  - Write at edge k into an empty FIFO with the FSM in IDLE: empty falls after edge k, and tx falls after edge k+1.
  - Frame length is exactly 10*BIT_CYCLES clocks.
  - tx_busy rises together with the tx start edge. It falls on the cycle the FSM returns to IDLE.
- wr_data is sampled only on an accepted write. Changing wr_data at other times has no effect on the frame in flight.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [1:0] tx_state_t {IDLE, START, DATA, STOP};
  - localparam DATA_BITS=8, STOP_BITS=1.
- Sub-module uart_tx_fifo, parameterized by DATA_W=8 and DEPTH:
  - ports: clk, reset, push, din, pop, dout, full, empty;
  - dout shows the head combinationally (first-word fall-through).
- uart_tx instantiates uart_tx_fifo and holds the FSM, the baud counter and the shift register.

Test Plan:
- Bench parameters are CLK_FREQ=1_000_000 and BAUD=100_000, giving BIT_CYCLES=10.
- Single byte: write 0x41 once -> tx goes low 1 clock after the write. The bench samples mid-bit and reads 0,1,0,0,0,0,0,1,0,1 (start, LSB first, stop) at 10 clocks per bit. tx_busy is high for exactly 100 clocks, then empty=1.
- Back-to-back: write 0x55 then 0xA3 on consecutive cycles -> two frames with no idle gap (the stop bit of frame 1 is followed directly by the start bit of frame 2). Decoded bytes are 0x55 then 0xA3; total busy time is 200 clocks.
- Full/overflow: write 0x01..0x05 on 5 consecutive cycles with the FSM idle -> the first byte is popped after 1 cycle, so 0x01..0x05 all fit (4 queued plus 1 in shift). A 6th write of 0x06 on the next cycle gets full=1 and an overflow pulse. Output is 0x01..0x05 and 0x06 never appears.
- Reset mid-frame: assert reset at clock 35 of a 0xFF frame -> tx=1 asynchronously (before the next edge) and empty=1. After release, a write of 0x0F produces one clean frame decoding to 0x0F.
- Idle stability: no writes for 500 clocks after reset -> tx stays at 1, tx_busy=0 and overflow=0 throughout.
- Default-parameter sanity: CLK_FREQ=100e6 and BAUD=9600 -> bit period is 10416 clocks (104.16 us). This decodes correctly with a 104167 ns-per-bit sampler.
